id_ex_stage: RTL and testbench

//   ID/EX pipeline stage between decode (register file + extender) and the ALU.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/skid_buffer.sv | 74 +++++++
 rtl/id_ex_stage.sv | 92 +++++++++
 tb/tb_id_ex_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the decode extender, the ID/EX stage and the ALU.
//   DATA_W / REG_W / CTRL_W / SHAMT_W : datapath widths
//   ALU_*                             : ALUControl encodings
//   is_imm_shift / is_var_shift       : shift-class decode of ALUControl
package cpu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned CTRL_W  = 5;
    localparam int unsigned SHAMT_W = 5;

    typedef logic [CTRL_W-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_SLTU = 5'b01000;
    localparam alu_ctrl_t ALU_SLL  = 5'b01110;
    localparam alu_ctrl_t ALU_SLLV = 5'b01111;
    localparam alu_ctrl_t ALU_SRL  = 5'b10000;
    localparam alu_ctrl_t ALU_SRLV = 5'b10001;
    localparam alu_ctrl_t ALU_SRA  = 5'b10010;
    localparam alu_ctrl_t ALU_SRAV = 5'b10011;

    // Shifts whose amount comes from the instruction's shamt field.
    function automatic logic is_imm_shift(input alu_ctrl_t ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

    // Shifts whose amount comes from the low bits of rs.
    function automatic logic is_var_shift(input alu_ctrl_t ctrl);
        return (ctrl == ALU_SLLV) || (ctrl == ALU_SRLV) || (ctrl == ALU_SRAV);
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: 2-entry valid/ready register with a registered in_ready.
//   clk, rst (async, active-high), flush (sync kill of both entries)
//   in_valid/in_ready/in_data   : upstream handshake
//   out_valid/out_ready/out_data: downstream handshake, out_data driven by the main register
module skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept, drain;

    assign accept = in_valid & ready_q;
    assign drain  = main_valid_q & out_ready;

    // ready_q is only ever 1 while the skid is empty, so accept and a
    // skid-to-main move never coincide.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!main_valid_q || drain)) begin
            main_d       = in_data;
            main_valid_d = 1'b1;
        end else if (accept) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
        ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register between decode and the ALU.
//   Selects operand A/B and the shift amount at capture time, then holds the bundle in a
//   2-entry skid buffer so in_ready is registered.
//   clk, rst (async, active-high), flush (sync kill)
//   in_*  : decode bundle with in_valid/in_ready handshake
//   out_* : ALU bundle with out_valid/out_ready handshake
//   stall_cnt : saturating count of out_valid && !out_ready cycles, present only when
//               ID_EX_STALL_CNT_EN is defined
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned CTRL_W = cpu_pkg::CTRL_W,
    parameter int unsigned REG_W  = cpu_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_ext_imm,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic              in_use_imm,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [4:0]        out_shamt,
    output logic [REG_W-1:0]  out_rd
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned BUNDLE_W = CTRL_W + 2 * DATA_W + 5 + REG_W;

    logic [DATA_W-1:0]   op_a, op_b;
    logic [4:0]          shamt;
    logic [BUNDLE_W-1:0] bundle_in, bundle_out;

    // Immediate shifts (SLL/SRL/SRA) shift rt, so rt takes the operand A slot.
    always_comb begin
        op_a  = in_rs_data;
        op_b  = in_use_imm ? in_ext_imm : in_rt_data;
        shamt = 5'd0;
        if (is_imm_shift(in_ctrl)) begin
            op_a  = in_rt_data;
            shamt = in_ext_imm[10:6];
        end else if (is_var_shift(in_ctrl)) begin
            shamt = in_rs_data[4:0];
        end
    end

    assign bundle_in = {in_ctrl, op_a, op_b, shamt, in_rd};

    skid_buffer #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (bundle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (bundle_out)
    );

    assign {out_ctrl, out_op_a, out_op_b, out_shamt, out_rd} = bundle_out;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a queue-based model.
module tb_id_ex_stage;

    localparam logic [4:0] C_ADD  = 5'b00010;
    localparam logic [4:0] C_SLTU = 5'b01000;
    localparam logic [4:0] C_SLL  = 5'b01110;
    localparam logic [4:0] C_SLLV = 5'b01111;
    localparam logic [4:0] C_SRL  = 5'b10000;
    localparam logic [4:0] C_SRLV = 5'b10001;
    localparam logic [4:0] C_SRA  = 5'b10010;
    localparam logic [4:0] C_SRAV = 5'b10011;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_ctrl;
    logic [31:0] in_ext_imm;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        in_use_imm;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_ctrl;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [4:0]  out_shamt;
    logic [4:0]  out_rd;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_ext_imm (in_ext_imm),
        .in_rs_data (in_rs_data),
        .in_rt_data (in_rt_data),
        .in_use_imm (in_use_imm),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_op_a   (out_op_a),
        .out_op_b   (out_op_b),
        .out_shamt  (out_shamt),
        .out_rd     (out_rd)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  shamt;
        logic [4:0]  rd;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned stall_exp = 0;
    logic [4:0]  ctrl_tab[8];

    // Expected ALU bundle straight from the operand/shamt rules.
    function automatic exp_t model(input logic [4:0] ctrl, input logic [31:0] imm,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic use_imm, input logic [4:0] rd);
        exp_t e;
        e.ctrl  = ctrl;
        e.rd    = rd;
        e.op_b  = use_imm ? imm : rt;
        e.op_a  = rs;
        e.shamt = 5'd0;
        if (ctrl == C_SLL || ctrl == C_SRL || ctrl == C_SRA) begin
            e.op_a  = rt;
            e.shamt = 5'((imm / 64) % 32);
        end else if (ctrl == C_SLLV || ctrl == C_SRLV || ctrl == C_SRAV) begin
            e.shamt = 5'(rs % 32);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] ctrl, input logic [31:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt, input logic use_imm,
                         input logic [4:0] rd);
        in_valid   = v;
        in_ctrl    = ctrl;
        in_ext_imm = imm;
        in_rs_data = rs;
        in_rt_data = rt;
        in_use_imm = use_imm;
        in_rd      = rd;
    endtask

    // Check outputs mid-cycle against the model, then advance model and DUT one clock.
    task automatic cycle();
        bit acc, drn;
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
            chk("out_op_a", out_op_a, q[0].op_a);
            chk("out_op_b", out_op_b, q[0].op_b);
            chk("out_shamt", 32'(out_shamt), 32'(q[0].shamt));
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
        end
`ifdef ID_EX_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_exp);
`endif
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready && (stall_exp != 32'hFFFF_FFFF)) stall_exp++;
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(model(in_ctrl, in_ext_imm, in_rs_data, in_rt_data,
                                       in_use_imm, in_rd));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, ctrl_tab[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
              1'($urandom), 5'($urandom));
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_ctrl"}, 32'(out_ctrl), 32'd0);
        chk({tag, "_out_op_a"}, out_op_a, 32'd0);
        chk({tag, "_out_op_b"}, out_op_b, 32'd0);
        chk({tag, "_out_shamt"}, 32'(out_shamt), 32'd0);
        chk({tag, "_out_rd"}, 32'(out_rd), 32'd0);
`ifdef ID_EX_STALL_CNT_EN
        chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        ctrl_tab[0] = C_ADD;  ctrl_tab[1] = C_SLTU; ctrl_tab[2] = C_SLL;  ctrl_tab[3] = C_SLLV;
        ctrl_tab[4] = C_SRL;  ctrl_tab[5] = C_SRLV; ctrl_tab[6] = C_SRA;  ctrl_tab[7] = C_SRAV;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_zero_state("reset");
        rst = 1'b0;

        // ADDI stream at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, C_ADD, 32'hFFFF_FFF0, $urandom, $urandom, 1'b1, 5'd5);
            cycle();
        end
        drive(1'b0, C_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        cycle();
        cycle();

        // Immediate and variable shift operand/shamt selection.
        drive(1'b1, C_SLL, 32'h0000_0140, 32'h1234_5678, 32'hCAFE_0001, 1'b0, 5'd3);
        cycle();
        drive(1'b1, C_SRAV, 32'h0000_0000, 32'h0000_0023, 32'h8000_0000, 1'b0, 5'd4);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Back-pressure: A, B accepted; C waits, then order A, B, C.
        out_ready = 1'b0;
        drive(1'b1, C_ADD, 32'hA, 32'hA0, 32'hA1, 1'b0, 5'd10);
        cycle();
        drive(1'b1, C_SRL, 32'h0000_07C0, 32'hB0, 32'hB1, 1'b1, 5'd11);
        cycle();
        drive(1'b1, C_SLLV, 32'hC, 32'hC0, 32'hC1, 1'b0, 5'd12);
        repeat (3) cycle();
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Flush with both entries full and a new bundle offered.
        out_ready = 1'b0;
        drive(1'b1, C_ADD, 32'h1, 32'h11, 32'h12, 1'b0, 5'd1);
        cycle();
        drive(1'b1, C_ADD, 32'h2, 32'h21, 32'h22, 1'b0, 5'd2);
        cycle();
        drive(1'b1, C_ADD, 32'h3, 32'h31, 32'h32, 1'b0, 5'd3);
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();

        // Seven stall cycles with out_valid high, then flush.
        out_ready = 1'b0;
        drive(1'b1, C_SLTU, 32'h7, 32'h70, 32'h71, 1'b0, 5'd7);
        cycle();
        in_valid = 1'b0;
        repeat (7) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();

        rand_run(400);

        // Asynchronous reset while a bundle is held.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, C_ADD, 32'h55, 32'h56, 32'h57, 1'b1, 5'd9);
        cycle();
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero_state("async_rst");
        q.delete();
        stall_exp = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        cycle();

        rand_run(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
